// File: rtl/rs_sign_pkg.sv
// Shared constants for the sign/magnitude to two's-complement restore block.
package rs_sign_pkg;
  localparam int RS_WIDTH  = 10;
  localparam int RS_DEPTH  = 4;
  localparam int RS_MAXP   = (1 << (RS_WIDTH - 1)) - 1;
  localparam int RS_MAXN   = 1 << (RS_WIDTH - 1);
  localparam int OVF_CNT_W = 8;
endpackage

// File: rtl/rs_fwft_fifo.sv
// First-word-fall-through FIFO; head word is visible while rd_valid is high.
module rs_fwft_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, do_wr, do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_valid = ~empty;
  // Zero the bus when idle so stale memory never shows after reset.
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/signed_value_restore.sv
// Converts sign/magnitude samples to saturated two's complement, one register
// stage then an FWFT output FIFO, with overflow statistics.
module signed_value_restore
  import rs_sign_pkg::*;
#(
  parameter int WIDTH = RS_WIDTH,
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mag,
  input  logic                 in_sign,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_overflow,
  output logic                 out_last,
  input  logic                 ovf_clear,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 ovf_sticky
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAXN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] conv_data;
  logic             conv_ovf;
  logic             accept, rdy_en, stage_valid;
  logic [WIDTH+1:0] stage_word;
  logic [CW-1:0]    fifo_count, occ;

  always_comb begin
    conv_data = in_mag;
    conv_ovf  = 1'b0;
    if (!in_sign) begin
      if (in_mag > MAXP) begin
        conv_data = MAXP;
        conv_ovf  = 1'b1;
      end
    end else if (in_mag > MAXN) begin
      conv_data = MAXN;
      conv_ovf  = 1'b1;
    end else begin
      conv_data = ~in_mag + 1'b1;
    end
  end

  // The stage always drains next cycle, so counting it here guarantees room.
  assign occ      = fifo_count + CW'(stage_valid);
  assign in_ready = rdy_en & (occ < CW'(DEPTH));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en      <= 1'b0;
      stage_valid <= 1'b0;
      stage_word  <= '0;
      ovf_count   <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      stage_valid <= accept;
      if (accept) stage_word <= {conv_ovf, in_last, conv_data};
      if (ovf_clear) begin
        ovf_count  <= '0;
        ovf_sticky <= 1'b0;
      end else if (accept && conv_ovf) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      end
    end
  end

  rs_fwft_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (stage_valid),
    .wr_data  (stage_word),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  ({out_overflow, out_last, out_data}),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_signed_value_restore.sv
// Directed bench for signed_value_restore: conversion, backpressure, stats, reset.
module tb_signed_value_restore;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0, in_sign = 1'b0, in_last = 1'b0;
  logic [9:0] in_mag = '0;
  logic       in_ready, out_valid, out_overflow, out_last;
  logic       out_ready = 1'b0, ovf_clear = 1'b0;
  logic [9:0] out_data;
  logic [7:0] ovf_count;
  logic       ovf_sticky;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  signed_value_restore #(.WIDTH(10), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_sign(in_sign), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_last(out_last), .ovf_clear(ovf_clear),
    .ovf_count(ovf_count), .ovf_sticky(ovf_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [9:0] m, input logic s, input logic l);
    int n = 0;
    in_mag = m; in_sign = s; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 20) begin step(); n++; end
    if (n >= 20) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  // Assumes out_ready=1: the sample seen here is transferred at the next edge.
  task automatic expect_out(input string tag, input logic [9:0] d, input logic o, input logic l);
    int n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    if (n >= 10) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_ovf"}, 32'(out_overflow), 32'(o));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
    step();
  endtask

  function automatic logic [11:0] model(input int m, input int s, input logic l);
    int v; logic o;
    if (s == 0) begin v = (m > 511) ? 511 : m;   o = (m > 511); end
    else        begin v = (m > 512) ? -512 : -m; o = (m > 512); end
    return {o, l, v[9:0]};
  endfunction

  typedef struct { logic [9:0] mag; logic sign; logic [9:0] data; logic ovf; } vec_t;
  vec_t vecs [6] = '{
    '{10'd0,    1'b0, 10'h000, 1'b0},
    '{10'd0,    1'b1, 10'h000, 1'b0},
    '{10'd511,  1'b0, 10'h1FF, 1'b0},
    '{10'd1023, 1'b0, 10'h1FF, 1'b1},
    '{10'd1023, 1'b1, 10'h200, 1'b1},
    '{10'd1,    1'b1, 10'h3FF, 1'b0}
  };

  logic [11:0] expq [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, stalls, got, first, lastc, drops;
    logic [11:0] e;
    // reset state
    #23;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    chk("rst_ovf_sticky", 32'(ovf_sticky), 0);
    step();
    reset_n = 1'b1;
    chk("rst_rel_in_ready_low", 32'(in_ready), 0);
    step();
    chk("rst_rel_in_ready", 32'(in_ready), 1);

    // latency: -5 appears exactly two cycles after acceptance
    out_ready = 1'b1;
    in_mag = 10'd5; in_sign = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_cyc1_valid", 32'(out_valid), 0);
    step();
    chk("lat_cyc2_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h3FB);
    chk("lat_ovf", 32'(out_overflow), 0);
    step();
    chk("lat_drained", 32'(out_valid), 0);

    // saturation corners queued behind a stalled sink
    out_ready = 1'b0;
    send(10'd600, 1'b0, 1'b0);
    send(10'd512, 1'b1, 1'b0);
    send(10'd513, 1'b1, 1'b1);
    step(); step();
    chk("sat_ovf_count", 32'(ovf_count), 2);
    chk("sat_ovf_sticky", 32'(ovf_sticky), 1);
    out_ready = 1'b1;
    expect_out("sat_p600", 10'h1FF, 1'b1, 1'b0);
    expect_out("sat_n512", 10'h200, 1'b0, 1'b0);
    expect_out("sat_n513", 10'h200, 1'b1, 1'b1);
    chk("sat_empty", 32'(out_valid), 0);

    // boundary table
    foreach (vecs[i]) begin
      send(vecs[i].mag, vecs[i].sign, 1'(i % 2));
      expect_out($sformatf("vec%0d", i), vecs[i].data, vecs[i].ovf, 1'(i % 2));
    end

    // backpressure: six offered, four fit
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 6) begin
        in_valid = 1'b1; in_mag = 10'(10 + acc); in_sign = 1'b0; in_last = acc[0];
      end
      if (in_ready && acc < 6) begin step(); acc++; end
      else step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_head_valid", 32'(out_valid), 1);
    chk("bp_head_data", 32'(out_data), 10);
    step();
    chk("bp_head_hold", 32'(out_data), 10);
    chk("bp_head_last_hold", 32'(out_last), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_out($sformatf("bp%0d", i), 10'(10 + i), 1'b0, 1'(i % 2));
    chk("bp_empty", 32'(out_valid), 0);

    // counter saturation and clear priority
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_mag = 10'd1023; in_sign = 1'b0; in_last = 1'b0;
      if (!in_ready) stalls++;
      step();
    end
    in_valid = 1'b0;
    chk("cnt_no_stall", 32'(stalls), 0);
    chk("cnt_sat_255", 32'(ovf_count), 255);
    chk("cnt_sticky", 32'(ovf_sticky), 1);
    in_valid = 1'b1; ovf_clear = 1'b1;
    step();
    in_valid = 1'b0; ovf_clear = 1'b0;
    chk("clr_count", 32'(ovf_count), 0);
    chk("clr_sticky", 32'(ovf_sticky), 0);
    send(10'd700, 1'b1, 1'b0);
    chk("post_clr_count", 32'(ovf_count), 1);
    chk("post_clr_sticky", 32'(ovf_sticky), 1);
    repeat (5) step();

    // mid-stream reset drops queued samples
    out_ready = 1'b0;
    send(10'd7, 1'b0, 1'b0);
    send(10'd8, 1'b0, 1'b0);
    send(10'd9, 1'b0, 1'b1);
    step(); step();
    chk("mrst_pre_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_data", 32'(out_data), 0);
    chk("mrst_in_ready", 32'(in_ready), 0);
    step();
    reset_n = 1'b1;
    step();
    chk("mrst_in_ready_up", 32'(in_ready), 1);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) got++;
      step();
    end
    chk("mrst_no_stale", 32'(got), 0);
    send(10'd3, 1'b0, 1'b1);
    expect_out("mrst_fresh", 10'd3, 1'b0, 1'b1);

    // random stream at full rate
    got = 0; first = -1; lastc = -1; drops = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          int m, s; logic l;
          m = int'($urandom_range(0, 1023));
          s = int'($urandom_range(0, 1));
          l = 1'($urandom_range(0, 1));
          in_mag = 10'(m); in_sign = 1'(s); in_last = l; in_valid = 1'b1;
          if (!in_ready) drops++;
          else expq.push_back(model(m, s, l));
          step();
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 230; c++) begin
          if (out_valid) begin
            if (expq.size() == 0) chk("rnd_extra", 1, 0);
            else begin
              e = expq.pop_front();
              chk($sformatf("rnd%0d", got), 32'({out_overflow, out_last, out_data}), 32'(e));
            end
            if (first < 0) first = c;
            lastc = c;
            got++;
          end
          step();
        end
      end
    join
    chk("rnd_in_ready_drops", 32'(drops), 0);
    chk("rnd_count", 32'(got), 200);
    chk("rnd_no_gaps", 32'(lastc - first + 1), 200);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/signed_value_restore.md
SIGNED_VALUE_RESTORE -- requirements
Module: signed_value_restore

Interface
REQ-001 SHALL have parameter WIDTH, default 10: sample width in bits, both magnitude and two's-complement.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input sample is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered sample.
REQ-007 SHALL have port in_mag, input, WIDTH bits: unsigned magnitude, 0..2^WIDTH-1.
REQ-008 SHALL have port in_sign, input, 1 bit: 1 means negative.
REQ-009 SHALL have port in_last, input, 1 bit: end-of-codeword marker, passed through.
REQ-010 SHALL have port out_valid, output, 1 bit: an output sample is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: the sink accepts the presented sample.
REQ-012 SHALL have port out_data, output, WIDTH bits: two's-complement result.
REQ-013 SHALL have port out_overflow, output, 1 bit: this sample was saturated.
REQ-014 SHALL have port out_last, output, 1 bit: in_last of this sample.
REQ-015 SHALL have port ovf_clear, input, 1 bit: synchronous clear of the overflow statistics.
REQ-016 SHALL have port ovf_count, output, 8 bits: saturating count of saturated samples.
REQ-017 SHALL have port ovf_sticky, output, 1 bit: at least one saturation since the last clear or reset.

Function
REQ-018 SHALL accept a sample in a cycle with in_valid=1 and in_ready=1; SHALL transfer an output in a cycle with out_valid=1 and out_ready=1.
REQ-019 SHALL convert as follows (MAXP=2^(WIDTH-1)-1, MAXN=2^(WIDTH-1)):
- sign=0, mag<=MAXP: data=mag, overflow 0.
- sign=0, mag>MAXP: data=MAXP, overflow 1.
- sign=1, mag<=MAXN: data=-mag, overflow 0; -0 yields 0.
- sign=1, mag>MAXN: data=-MAXN, overflow 1.
REQ-020 SHALL register the conversion in one stage (stage_valid), then write it to a first-word-fall-through FIFO of DEPTH entries.
REQ-021 SHALL show an accepted sample on out_valid exactly 2 cycles after acceptance when the FIFO is empty and the stage is free.
REQ-022 SHALL drive in_ready = ((fifo_count + stage_valid) < DEPTH), from registered state only, with no combinational path from out_ready.
REQ-023 SHALL accept writes and reads in the same cycle when the FIFO is full, so that count is unchanged.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH, and SHALL never lose or duplicate a sample.
REQ-025 SHALL hold out_data, out_overflow and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL increment ovf_count, saturating at 255, and set ovf_sticky when an overflow sample is accepted at the input.
REQ-027 SHALL give ovf_clear priority over an increment in the same cycle: the result is count 0, sticky 0, and that cycle's overflow is not counted.
REQ-028 SHALL preserve sample order and keep in_last aligned with its sample.

Reset
REQ-029 SHALL, while reset_n=0, force in_ready=0, out_valid=0, out_data=0, out_overflow=0, out_last=0, ovf_count=0, ovf_sticky=0, pointers and stage empty.
REQ-030 SHALL discard all in-flight samples on a mid-stream reset, and SHALL raise in_ready in the first clock after reset_n deasserts.

Structure
REQ-031 SHALL place WIDTH/DEPTH defaults, MAXP/MAXN constants and the overflow-counter width in shared package rs_sign_pkg.
REQ-032 SHALL implement the FIFO as one sub-module, rs_fwft_fifo, with parameters WIDTH+2 (data, overflow, last) and DEPTH; conversion and statistics stay in the top.

Verification
REQ-033 SHALL cover: mag=5, sign=1 -> out_data=0x3FB, overflow 0, out_valid 2 cycles later.
REQ-034 SHALL cover: mag=600, sign=0 -> 0x1FF, overflow 1; mag=512, sign=1 -> 0x200, overflow 0; mag=513, sign=1 -> 0x200, overflow 1; ovf_count=2.
REQ-035 SHALL cover: out_ready=0 while sending 6 samples -> in_ready drops after 4 are accepted; releasing out_ready -> all 4 emerge in order with in_last intact.
REQ-036 SHALL cover: 300 overflow samples -> ovf_count=255, sticky 1; ovf_clear together with an overflow sample -> count 0, sticky 0.
REQ-037 SHALL cover: reset_n pulsed low with 3 samples queued -> out_valid=0 immediately, and no stale sample after reset.
REQ-038 SHALL cover: continuous in_valid and out_ready with a random stream -> one sample per cycle throughout, matching the reference conversion model.
